// File: rtl/r22_twiddle_sequencer.sv
// r22_twiddle_sequencer
// Control sequencer for one radix-2^2 SDF stage. It counts accepted input
// samples, tracks fill / run / drain of the stage's M/2 delay line, and issues
// the butterfly-output valid. It also issues the twiddle-table address for each
// butterfly output. Valid and bypass flags are delayed to line up with the
// table's output register.
//
// Ports:
//   clock      master clock, rising edge
//   reset      asynchronous, active-high reset
//   di_en      input sample accepted this cycle (ignored while busy)
//   flush      single-cycle request to drain the delay line after the frame
//   busy       high while draining; upstream must hold di_en low
//   bf_en      butterfly output valid
//   drain      datapath shifts the delay line with zero input this cycle
//   tw_addr    twiddle address for the current bf_en output (held otherwise)
//   tw_en      twiddle valid at table output (bf_en delayed TW_FF cycles)
//   tw_bypass  twiddle address 0, multiplier bypassed (delayed TW_FF cycles)
//   frame_end  pulses with the bf_en of output index M-1
module r22_twiddle_sequencer #(
  parameter int LOG_N = 6,
  parameter int LOG_M = 6,
  parameter int TW_FF = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic             flush,
  output logic             busy,
  output logic             bf_en,
  output logic             drain,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_en,
  output logic             tw_bypass,
  output logic             frame_end
);

  localparam logic [LOG_M-1:0] HALF_LAST  = LOG_M'((1 << (LOG_M - 1)) - 1);
  localparam logic [LOG_M-1:0] FRAME_LAST = '1;
  localparam logic [LOG_M-2:0] DRAIN_LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t           state;
  logic [LOG_M-1:0] di_cnt;
  logic [LOG_M-1:0] bf_cnt;
  logic [LOG_M-2:0] dr_cnt;
  logic             flush_pend;

  logic             go_drain;
  logic             emit_drain;
  logic             emit;
  logic [LOG_N-1:0] num;
  logic [1:0]       sel;
  logic [LOG_N-1:0] next_addr;
  logic             bypass_pre;

  always_comb begin
    // Drain starts only on a frame boundary with no sample arriving.
    go_drain   = (state == RUN) && (di_cnt == '0) && !di_en && (flush || flush_pend);
    // Covers the entry cycle and every drain cycle except the final one.
    emit_drain = go_drain || ((state == DRAIN) && (dr_cnt != DRAIN_LAST));
    emit       = emit_drain || ((state == RUN) && di_en);

    // Quarter order 0,2,1,3: select is the top two index bits swapped.
    num        = LOG_N'(bf_cnt[LOG_M-3:0]) << (LOG_N - LOG_M);
    sel        = {bf_cnt[LOG_M-2], bf_cnt[LOG_M-1]};
    next_addr  = num * LOG_N'(sel);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      di_cnt     <= '0;
      bf_cnt     <= '0;
      dr_cnt     <= '0;
      flush_pend <= 1'b0;
      busy       <= 1'b0;
      bf_en      <= 1'b0;
      drain      <= 1'b0;
      frame_end  <= 1'b0;
      tw_addr    <= '0;
    end else begin
      busy      <= emit_drain;
      bf_en     <= emit;
      drain     <= emit_drain;
      frame_end <= emit && (bf_cnt == FRAME_LAST);
      if (emit) begin
        tw_addr <= next_addr;
        bf_cnt  <= bf_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (di_en) begin
            di_cnt <= di_cnt + 1'b1;
            state  <= FILL;
          end
        end
        FILL: begin
          if (di_en) begin
            di_cnt <= di_cnt + 1'b1;
            if (di_cnt == HALF_LAST) state <= RUN;
          end
        end
        RUN: begin
          if (go_drain) begin
            state  <= DRAIN;
            dr_cnt <= '0;
          end else begin
            if (flush) flush_pend <= 1'b1;
            if (di_en) di_cnt <= di_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dr_cnt == DRAIN_LAST) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
          end else begin
            dr_cnt <= dr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bypass_pre = bf_en && (tw_addr == '0);

  generate
    if (TW_FF == 0) begin : g_tw_comb
      assign tw_en     = bf_en;
      assign tw_bypass = bypass_pre;
    end else begin : g_tw_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          tw_en     <= 1'b0;
          tw_bypass <= 1'b0;
        end else begin
          tw_en     <= bf_en;
          tw_bypass <= bypass_pre;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_r22_twiddle_sequencer.sv
// Bench for r22_twiddle_sequencer: two instances (default stage, and
// LOG_M=4/TW_FF=0 stage) share one stimulus stream and are checked every
// cycle against a count-based reference model.
module tb_r22_twiddle_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic di_en = 1'b0;
  logic flush = 1'b0;

  logic       a_busy, a_bf_en, a_drain, a_tw_en, a_tw_bypass, a_frame_end;
  logic [5:0] a_tw_addr;
  logic       b_busy, b_bf_en, b_drain, b_tw_en, b_tw_bypass, b_frame_end;
  logic [5:0] b_tw_addr;

  always #5 clock = ~clock;

  r22_twiddle_sequencer #(.LOG_N(6), .LOG_M(6), .TW_FF(1)) dut_a (
    .clock(clock), .reset(reset), .di_en(di_en), .flush(flush),
    .busy(a_busy), .bf_en(a_bf_en), .drain(a_drain), .tw_addr(a_tw_addr),
    .tw_en(a_tw_en), .tw_bypass(a_tw_bypass), .frame_end(a_frame_end)
  );

  r22_twiddle_sequencer #(.LOG_N(6), .LOG_M(4), .TW_FF(0)) dut_b (
    .clock(clock), .reset(reset), .di_en(di_en), .flush(flush),
    .busy(b_busy), .bf_en(b_bf_en), .drain(b_drain), .tw_addr(b_tw_addr),
    .tw_en(b_tw_en), .tw_bypass(b_tw_bypass), .frame_end(b_frame_end)
  );

  logic       o_busy [2], o_bf [2], o_drain [2], o_twen [2], o_byp [2], o_fe [2];
  logic [5:0] o_addr [2];
  assign o_busy[0] = a_busy;    assign o_busy[1] = b_busy;
  assign o_bf[0]   = a_bf_en;   assign o_bf[1]   = b_bf_en;
  assign o_drain[0]= a_drain;   assign o_drain[1]= b_drain;
  assign o_twen[0] = a_tw_en;   assign o_twen[1] = b_tw_en;
  assign o_byp[0]  = a_tw_bypass; assign o_byp[1] = b_tw_bypass;
  assign o_fe[0]   = a_frame_end; assign o_fe[1]  = b_frame_end;
  assign o_addr[0] = a_tw_addr; assign o_addr[1] = b_tw_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int a_bf_seen = 0;

  // Reference model, per instance
  int    mm   [2] = '{64, 16};
  int    nm   [2] = '{1, 4};     // N/M
  int    twff [2] = '{1, 0};
  string nam  [2] = '{"A", "B"};
  int total_in [2];
  int drain_rem[2];
  int out_cnt  [2];
  bit pend     [2];
  bit e_bf [2], e_drain [2], e_busy [2], e_fe [2], e_twen [2], e_byp [2];
  bit p_en [2], p_byp [2];
  int e_addr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int k, input int m, input int n_over_m);
    int q, r, s;
    q = k / (m / 4);
    r = k % (m / 4);
    case (q)
      0: s = 0;
      1: s = 2;
      2: s = 1;
      default: s = 3;
    endcase
    return (r * n_over_m * s) % 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      total_in[i] = 0; drain_rem[i] = 0; out_cnt[i] = 0; pend[i] = 0;
      e_bf[i] = 0; e_drain[i] = 0; e_busy[i] = 0; e_fe[i] = 0;
      e_twen[i] = 0; e_byp[i] = 0; p_en[i] = 0; p_byp[i] = 0; e_addr[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input bit di, input bit fl);
    int m;
    int k;
    bit emit;
    bit dr;
    m = mm[i];
    emit = 0;
    dr = 0;
    p_en[i]  = e_bf[i];
    p_byp[i] = e_bf[i] && (e_addr[i] == 0);
    if (drain_rem[i] > 0) begin
      drain_rem[i]--;
      if (drain_rem[i] > 0) begin emit = 1; dr = 1; end
    end else if (total_in[i] >= m / 2) begin
      if ((total_in[i] % m == 0) && !di && (fl || pend[i])) begin
        drain_rem[i] = m / 2;
        total_in[i] = 0;
        pend[i] = 0;
        emit = 1;
        dr = 1;
      end else begin
        if (fl) pend[i] = 1;
        if (di) begin emit = 1; total_in[i]++; end
      end
    end else if (di) begin
      total_in[i]++;
    end
    e_bf[i] = emit;
    e_drain[i] = dr;
    e_busy[i] = drain_rem[i] > 0;
    e_fe[i] = 0;
    if (emit) begin
      k = out_cnt[i] % m;
      e_addr[i] = addr_of(k, m, nm[i]);
      e_fe[i] = (k == m - 1);
      out_cnt[i]++;
    end
    if (twff[i] != 0) begin
      e_twen[i] = p_en[i];
      e_byp[i]  = p_byp[i];
    end else begin
      e_twen[i] = e_bf[i];
      e_byp[i]  = e_bf[i] && (e_addr[i] == 0);
    end
  endtask

  task automatic check_inst(input int i);
    chk({nam[i], ".busy"},      32'(o_busy[i]),  32'(e_busy[i]));
    chk({nam[i], ".bf_en"},     32'(o_bf[i]),    32'(e_bf[i]));
    chk({nam[i], ".drain"},     32'(o_drain[i]), 32'(e_drain[i]));
    chk({nam[i], ".frame_end"}, 32'(o_fe[i]),    32'(e_fe[i]));
    chk({nam[i], ".tw_addr"},   32'(o_addr[i]),  32'(e_addr[i]));
    chk({nam[i], ".tw_en"},     32'(o_twen[i]),  32'(e_twen[i]));
    chk({nam[i], ".tw_bypass"}, 32'(o_byp[i]),   32'(e_byp[i]));
  endtask

  // Called and returns at posedge+1
  task automatic step(input bit di, input bit fl);
    di_en = di;
    flush = fl;
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_edge(i, di, fl);
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
    if (a_bf_en === 1'b1) a_bf_seen++;
    di_en = 0;
    flush = 0;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    di_en = 0;
    flush = 0;
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk({nam[i], ".rst_busy"},  32'(o_busy[i]),  32'd0);
      chk({nam[i], ".rst_bf_en"}, 32'(o_bf[i]),    32'd0);
      chk({nam[i], ".rst_drain"}, 32'(o_drain[i]), 32'd0);
      chk({nam[i], ".rst_fe"},    32'(o_fe[i]),    32'd0);
      chk({nam[i], ".rst_addr"},  32'(o_addr[i]),  32'd0);
      chk({nam[i], ".rst_twen"},  32'(o_twen[i]),  32'd0);
      chk({nam[i], ".rst_byp"},   32'(o_byp[i]),   32'd0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // 1: run partway into a frame, then reset between edges
    for (int n = 0; n < 40; n++) step(1, 0);
    do_reset();

    // 2: continuous input across more than a full output frame
    for (int n = 0; n < 100; n++) step(1, 0);
    for (int n = 0; n < 4; n++) step(0, 0);
    do_reset();

    // 3: flush at di_cnt=40, inputs continue to end of frame, then drain
    while (total_in[0] != 40) step(1, 0);
    step(1, 1);
    while (total_in[0] % 64 != 0) step(1, 0);
    for (int n = 0; n < 40; n++) step(0, 0);
    chk("A.drain_idle_busy", 32'(a_busy), 32'd0);
    do_reset();

    // 4: gapped input, one sample every third cycle
    a_bf_seen = 0;
    for (int n = 0; n < 128; n++) begin
      step(1, 0);
      step(0, 0);
      step(0, 0);
    end
    chk("A.gap_bf_count", 32'(a_bf_seen), 32'd96);
    do_reset();

    // 6: reset during the tenth drain cycle
    for (int n = 0; n < 64; n++) step(1, 0);
    step(0, 1);
    for (int n = 0; n < 9; n++) step(0, 0);
    chk("A.pre_rst_busy", 32'(a_busy), 32'd1);
    do_reset();
    a_bf_seen = 0;
    for (int n = 0; n < 32; n++) step(1, 0);
    chk("A.refill_no_bf", 32'(a_bf_seen), 32'd0);
    for (int n = 0; n < 8; n++) step(1, 0);
    do_reset();

    // Randomized traffic with occasional flush requests
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 30) == 0));
    end
    for (int n = 0; n < 40; n++) step(0, 1'($urandom_range(0, 5) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
